// File: rtl/wav_apb_csr_array.sv
// APB register bank with NUM_CH channels of CTRL / sticky STATUS / MASK.
// Also provides a registered interrupt, a registered debug mux and scan-mode forcing of the outputs.
module wav_apb_csr_array #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned STAT_W      = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] CTRL_RESET  = 32'h0
) (
    input  logic                     RegClk,
    input  logic                     RegResetn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDR_WIDTH-1:0]    PADDR,
    input  logic [31:0]              PWDATA,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [NUM_CH*STAT_W-1:0] hw_evt,
    output logic [NUM_CH*32-1:0]     swi_ctrl,
    output logic                     irq,
    output logic [31:0]              debug_bus,
    input  logic                     dft_core_scan_mode
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DBG_W  = 4;
    localparam int unsigned BLK_W  = ADDR_WIDTH - 4;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  setup;
    logic                  done;
    logic                  commit;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  write_q;

    logic                  int_en_q;
    logic [DBG_W-1:0]      dbg_ch_q;
    logic                  dbg_src_q;
    logic [DATA_W-1:0]     ctrl_q   [NUM_CH];
    logic [STAT_W-1:0]     status_q [NUM_CH];
    logic [STAT_W-1:0]     mask_q   [NUM_CH];
    logic                  irq_q;
    logic [DATA_W-1:0]     dbg_q;

    logic [BLK_W-1:0]      blk;
    logic [3:0]            off;
    logic                  hit_glb;
    logic                  hit_sum;
    logic [NUM_CH-1:0]     hit_ch;
    logic                  err;
    logic [DATA_W-1:0]     rdata;
    logic [NUM_CH-1:0]     int_sum;
    logic [STAT_W-1:0]     stat_clr [NUM_CH];
    logic [DATA_W-1:0]     dbg_d;

    assign done   = (state_q == ST_ACCESS) && PENABLE && (cnt_q == CNT_W'(WAIT_STATES));
    assign commit = done && PSEL && write_q && !err;

    // APB state register
    always_ff @(posedge RegClk) begin
        if (!RegResetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // APB next state; losing PSEL mid-access abandons the transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSEL || done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q < CNT_W'(WAIT_STATES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Setup-phase capture of the request
    always_ff @(posedge RegClk) begin
        if (!RegResetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (setup) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
        end
    end

    // Address decode: block 0 holds the globals, block i+1 holds channel i
    always_comb begin
        blk     = addr_q[ADDR_WIDTH-1:4];
        off     = addr_q[3:0];
        hit_glb = (blk == '0) && (off == 4'h0);
        hit_sum = (blk == '0) && (off == 4'h4);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            hit_ch[i] = (blk == BLK_W'(i + 1));
        end
        err = !(hit_glb || hit_sum ||
                ((|hit_ch) && (off == 4'h0 || off == 4'h4 || off == 4'h8)))
              || (hit_sum && write_q)
              || (addr_q[1:0] != 2'b00);
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            int_sum[i]  = |(status_q[i] & mask_q[i]);
            stat_clr[i] = (commit && hit_ch[i] && off == 4'h4) ? wdata_q[STAT_W-1:0] : '0;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_glb) rdata = {23'b0, dbg_src_q, dbg_ch_q, 3'b0, int_en_q};
        if (hit_sum) rdata = DATA_W'(int_sum);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (hit_ch[i]) begin
                case (off)
                    4'h0:    rdata = ctrl_q[i];
                    4'h4:    rdata = DATA_W'(status_q[i]);
                    4'h8:    rdata = DATA_W'(mask_q[i]);
                    default: rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        dbg_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (dbg_ch_q == DBG_W'(i)) dbg_d = dbg_src_q ? DATA_W'(status_q[i]) : ctrl_q[i];
        end
    end

    // Register file; a same-cycle event beats a W1C clear
    always_ff @(posedge RegClk) begin
        if (!RegResetn) begin
            int_en_q  <= 1'b0;
            dbg_ch_q  <= '0;
            dbg_src_q <= 1'b0;
            irq_q     <= 1'b0;
            dbg_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ctrl_q[i]   <= CTRL_RESET;
                status_q[i] <= '0;
                mask_q[i]   <= '0;
            end
        end else begin
            if (commit && hit_glb) begin
                int_en_q  <= wdata_q[0];
                dbg_ch_q  <= wdata_q[7:4];
                dbg_src_q <= wdata_q[8];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (commit && hit_ch[i] && off == 4'h0) ctrl_q[i] <= wdata_q;
                if (commit && hit_ch[i] && off == 4'h8) mask_q[i] <= wdata_q[STAT_W-1:0];
                status_q[i] <= (status_q[i] & ~stat_clr[i]) | hw_evt[i*STAT_W +: STAT_W];
            end
            irq_q <= int_en_q && (|int_sum);
            dbg_q <= dbg_d;
        end
    end

    assign PREADY    = done;
    assign PSLVERR   = done && err;
    assign PRDATA    = (done && !err) ? rdata : '0;
    assign irq       = irq_q && !dft_core_scan_mode;
    assign debug_bus = dbg_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            swi_ctrl[i*DATA_W +: DATA_W] = dft_core_scan_mode ? CTRL_RESET : ctrl_q[i];
        end
    end

endmodule

// File: tb/tb_wav_apb_csr_array.sv
// Bench for wav_apb_csr_array: vector table, directed corner sequences, then random ops vs. a register model.
module tb_wav_apb_csr_array;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned STAT_W = 8;
    localparam int unsigned WS     = 3;
    localparam int unsigned AW     = 8;
    localparam logic [31:0] CR     = 32'hC0DE_0001;

    logic                     RegClk;
    logic                     RegResetn;
    logic                     PSEL, PENABLE, PWRITE;
    logic [AW-1:0]            PADDR;
    logic [31:0]              PWDATA, PRDATA;
    logic                     PREADY, PSLVERR;
    logic [NUM_CH*STAT_W-1:0] hw_evt;
    logic [NUM_CH*32-1:0]     swi_ctrl;
    logic                     irq;
    logic [31:0]              debug_bus;
    logic                     dft_core_scan_mode;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_ctrl [NUM_CH];
    logic [31:0] m_stat [NUM_CH];
    logic [31:0] m_mask [NUM_CH];
    logic [31:0] m_glb;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    wav_apb_csr_array #(
        .ADDR_WIDTH(AW), .NUM_CH(NUM_CH), .STAT_W(STAT_W),
        .WAIT_STATES(WS), .CTRL_RESET(CR)
    ) dut (
        .RegClk(RegClk), .RegResetn(RegResetn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .hw_evt(hw_evt), .swi_ctrl(swi_ctrl), .irq(irq),
        .debug_bus(debug_bus), .dft_core_scan_mode(dft_core_scan_mode)
    );

    initial RegClk = 1'b0;
    always #5 RegClk = ~RegClk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void m_reset();
        m_glb = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_ctrl[i] = CR;
            m_stat[i] = 0;
            m_mask[i] = 0;
        end
    endfunction

    function automatic logic m_err(input logic [7:0] a, input logic w);
        int ai = int'(a);
        if (ai % 4 != 0) return 1'b1;
        if (ai == 0) return 1'b0;
        if (ai == 4) return w;
        if (ai < 16) return 1'b1;
        if ((ai - 16) / 16 >= NUM_CH) return 1'b1;
        return (ai % 16) == 12;
    endfunction

    function automatic logic [31:0] m_intsum();
        logic [31:0] s = 0;
        for (int i = 0; i < NUM_CH; i++)
            if ((m_stat[i] & m_mask[i]) != 0) s = s | (32'd1 << i);
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int ai = int'(a);
        int ch = (ai - 16) / 16;
        if (ai == 0) return m_glb;
        if (ai == 4) return m_intsum();
        if (ai < 16 || ch >= NUM_CH) return 0;
        if (ai % 16 == 0) return m_ctrl[ch];
        if (ai % 16 == 4) return m_stat[ch];
        return m_mask[ch];
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [31:0] d);
        int ai = int'(a);
        int ch = (ai - 16) / 16;
        if (ai == 0) m_glb = d & 32'h0000_01F1;
        else if (ai % 16 == 0) m_ctrl[ch] = d;
        else if (ai % 16 == 4) m_stat[ch] = m_stat[ch] & ~(d & 32'hFF);
        else if (ai % 16 == 8) m_mask[ch] = d & 32'hFF;
    endfunction

    function automatic void m_event(input logic [31:0] evt);
        for (int i = 0; i < NUM_CH; i++) m_stat[i] = m_stat[i] | ((evt >> (8 * i)) & 32'hFF);
    endfunction

    function automatic logic [31:0] m_dbg();
        int ch = int'((m_glb >> 4) & 32'hF);
        if (ch >= NUM_CH) return 0;
        return m_glb[8] ? m_stat[ch] : m_ctrl[ch];
    endfunction

    // ---------------- APB driver ----------------
    // Entered and left at #1 after a rising edge; evt is driven during the PREADY cycle.
    task automatic apb(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [31:0] evt,
                       output logic [31:0] rd, output logic er, output int cyc);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge RegClk); #1;
        PENABLE = 1'b1;
        cyc = 0; rd = 0; er = 1'b0;
        forever begin
            @(negedge RegClk);
            cyc++;
            if (PREADY === 1'b1) begin
                rd = PRDATA; er = PSLVERR; hw_evt = evt;
                break;
            end
            if (cyc >= 20) begin
                n_vec++; n_bad++;
                $display("FAIL pready_timeout: addr %02h no PREADY after %0d cycles", a, cyc);
                break;
            end
            @(posedge RegClk); #1;
        end
        @(posedge RegClk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; hw_evt = '0;
    endtask

    task automatic op(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [31:0] evt,
                      output logic [31:0] rd, output logic er);
        int  cyc;
        logic me = m_err(a, w);
        apb(a, w, d, evt, rd, er, cyc);
        check("access_cycles", 32'(cyc), 32'(WS + 1));
        if (w && !me) m_write(a, d);
        m_event(evt);
    endtask

    task automatic pulse(input logic [31:0] evt);
        hw_evt = evt;
        @(posedge RegClk); #1;
        hw_evt = '0;
        m_event(evt);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic er;
        op(a, 1'b0, 0, 0, rd, er);
        check({nm, "_err"}, 32'(er), 0);
        check(nm, rd, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] evt);
        logic [31:0] rd; logic er;
        op(a, 1'b1, d, evt, rd, er);
        check("write_err", 32'(er), 0);
    endtask

    task automatic chk_swi(input string nm);
        for (int i = 0; i < NUM_CH; i++) check(nm, swi_ctrl[32*i +: 32], m_ctrl[i]);
    endtask

    task automatic push(input logic [7:0] a, input logic w, input logic [31:0] d,
                        input logic e, input logic [31:0] r);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.exp_err = e; v.exp_rd = r;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd, d, evt;
        logic        er, w, exp_err;
        logic [7:0]  a;
        int          r;

        RegResetn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; hw_evt = '0; dft_core_scan_mode = 1'b0;
        m_reset();

        // vector table: reset readback and error responses
        push(8'h00, 0, 0, 0, 0);
        push(8'h04, 0, 0, 0, 0);
        for (int i = 0; i < NUM_CH; i++) begin
            push(8'(16 + 16 * i), 0, 0, 0, CR);
            push(8'(20 + 16 * i), 0, 0, 0, 0);
            push(8'(24 + 16 * i), 0, 0, 0, 0);
        end
        push(8'h08, 0, 0, 1, 0);
        push(8'h0C, 0, 0, 1, 0);
        push(8'h50, 0, 0, 1, 0);
        push(8'h04, 1, 32'hFFFF_FFFF, 1, 0);
        push(8'h11, 0, 0, 1, 0);
        push(8'h11, 1, 32'h1234_5678, 1, 0);
        push(8'h0C, 1, 32'hFFFF_FFFF, 1, 0);
        push(8'h50, 1, 32'hFFFF_FFFF, 1, 0);
        push(8'h1C, 1, 32'hFFFF_FFFF, 1, 0);
        push(8'h10, 0, 0, 0, CR);
        push(8'h00, 0, 0, 0, 0);
        push(8'h04, 0, 0, 0, 0);

        repeat (3) @(posedge RegClk);
        #1;
        check("rst_pready", 32'(PREADY), 0);
        check("rst_pslverr", 32'(PSLVERR), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_debug_bus", debug_bus, 0);
        chk_swi("rst_swi_ctrl");
        RegResetn = 1'b1;
        @(posedge RegClk); #1;

        foreach (tbl[k]) begin
            op(tbl[k].addr, tbl[k].wr, tbl[k].wdata, 0, rd, er);
            check($sformatf("tbl%0d_err", k), 32'(er), 32'(tbl[k].exp_err));
            if (!tbl[k].wr && !tbl[k].exp_err) check($sformatf("tbl%0d_rd", k), rd, tbl[k].exp_rd);
        end

        // wait-state write to CTRL_2
        wr(8'h30, 32'hA5A5_1234, 0);
        check("ctrl2_swi", swi_ctrl[95:64], 32'hA5A5_1234);
        rd_chk("ctrl2_rd", 8'h30, 32'hA5A5_1234);

        // interrupt path
        wr(8'h28, 32'h1, 0);
        wr(8'h00, 32'h1, 0);
        pulse(32'h0000_0100);
        check("irq_one_edge", 32'(irq), 0);
        @(posedge RegClk); #1;
        check("irq_two_edges", 32'(irq), 1);
        rd_chk("status1_rd", 8'h24, 32'h01);
        rd_chk("intsum_rd", 8'h04, 32'h02);
        wr(8'h24, 32'h1, 0);
        check("irq_at_clear", 32'(irq), 1);
        @(posedge RegClk); #1;
        check("irq_after_clear", 32'(irq), 0);

        // event vs. W1C collision
        pulse(32'h0000_0008);
        wr(8'h14, 32'h08, 32'h0000_0008);
        rd_chk("collision_set_wins", 8'h14, 32'h08);
        wr(8'h14, 32'h08, 0);
        rd_chk("w1c_clears", 8'h14, 32'h00);

        // debug mux
        pulse(32'h5500_0000);
        wr(8'h00, 32'h0000_0130, 0);
        @(posedge RegClk); #1;
        check("debug_status3", debug_bus, 32'h55);
        wr(8'h00, 32'h0000_0140, 0);
        @(posedge RegClk); #1;
        check("debug_ch_oob", debug_bus, 0);
        wr(8'h00, 32'h0000_0020, 0);
        @(posedge RegClk); #1;
        check("debug_ctrl2", debug_bus, 32'hA5A5_1234);

        // scan-mode forcing
        pulse(32'h0000_0100);
        wr(8'h00, 32'h1, 0);
        @(posedge RegClk); #1;
        check("irq_pre_dft", 32'(irq), 1);
        dft_core_scan_mode = 1'b1; #1;
        check("dft_irq", 32'(irq), 0);
        for (int i = 0; i < NUM_CH; i++) check("dft_swi", swi_ctrl[32*i +: 32], CR);
        dft_core_scan_mode = 1'b0; #1;
        check("dft_off_irq", 32'(irq), 1);
        chk_swi("dft_off_swi");

        // reset during the wait of a write
        @(posedge RegClk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 32'hDEAD_BEEF;
        @(posedge RegClk); #1;
        PENABLE = 1'b1;
        @(posedge RegClk); #1;
        RegResetn = 1'b0;
        @(posedge RegClk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        m_reset();
        check("midrst_pready", 32'(PREADY), 0);
        check("midrst_irq", 32'(irq), 0);
        check("midrst_debug", debug_bus, 0);
        chk_swi("midrst_swi");
        RegResetn = 1'b1;
        @(posedge RegClk); #1;
        rd_chk("midrst_ctrl1", 8'h20, CR);
        rd_chk("midrst_ctrl2", 8'h30, CR);

        // randomized operations against the model
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 3));
            evt = $urandom & $urandom & $urandom;
            if (r == 0) begin
                pulse(evt);
            end else begin
                r = int'($urandom_range(0, 17));
                if (r < 12) a = 8'(16 + 16 * (r / 3) + 4 * (r % 3));
                else begin
                    case (r)
                        12:      a = 8'h00;
                        13:      a = 8'h04;
                        14:      a = 8'h0C;
                        15:      a = 8'h50;
                        16:      a = 8'h1C;
                        default: a = 8'h22;
                    endcase
                end
                w = 1'($urandom_range(0, 1));
                d = $urandom;
                exp_err = m_err(a, w);
                rd = m_read(a);
                d = (r == 12) ? (d & 32'h0000_01FF) : d;
                begin
                    logic [31:0] got;
                    logic [31:0] e2 = (r % 2 == 1) ? evt : 32'h0;
                    op(a, w, d, e2, got, er);
                    check($sformatf("rnd%0d_err_a%02h", n, a), 32'(er), 32'(exp_err));
                    if (!w && !exp_err) check($sformatf("rnd%0d_rd_a%02h", n, a), got, rd);
                end
            end
            @(posedge RegClk); #1;
            check($sformatf("rnd%0d_irq", n), 32'(irq), 32'((m_glb[0] == 1'b1) && (m_intsum() != 0)));
            check($sformatf("rnd%0d_debug", n), debug_bus, m_dbg());
            chk_swi("rnd_swi");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wav_apb_csr_array.md
# wav_apb_csr_array

Parametrised APB register bank. It provides NUM_CH identical channels, each with a control register, a sticky event-status register and an interrupt mask, behind a wait-state-capable APB slave. It also provides a registered interrupt, a registered debug-bus mux and core-scan forcing of the control outputs. It sits between the APB fabric and multi-lane datapath blocks that need per-lane control and event reporting.

## Interface
Parameters:
- ADDR_WIDTH, 8: APB address width. Requirement: 16 + 16·NUM_CH ≤ 2^ADDR_WIDTH.
- NUM_CH, 4: number of channels, range 1–15.
- STAT_W, 8: number of status/mask bits per channel, range 1–32.
- WAIT_STATES, 0: number of extra access cycles before PREADY, range 0–7.
- CTRL_RESET, 32'h0: reset value of every channel CTRL register.

Ports:
- RegClk, input, 1: the single clock.
- RegResetn, input, 1: reset. Reset is synchronous and active-low.
- PSEL, PENABLE, PWRITE, input, 1 each: APB control.
- PADDR, input, ADDR_WIDTH: APB address.
- PWDATA, input, 32: APB write data.
- PRDATA, output, 32: read data. Valid only while PREADY=1; 0 otherwise.
- PREADY, output, 1: transfer completion.
- PSLVERR, output, 1: error response. Valid only while PREADY=1.
- hw_evt, input, NUM_CH·STAT_W: single-cycle event pulses. Channel i uses bits [i·STAT_W +: STAT_W].
- swi_ctrl, output, NUM_CH·32: CTRL register contents. Channel i uses bits [i·32 +: 32].
- irq, output, 1: registered interrupt.
- debug_bus, output, 32: registered debug mux output.
- dft_core_scan_mode, input, 1: test mode. When 1, swi_ctrl is forced to CTRL_RESET per channel and irq is forced to 0. The forcing is combinational and does not alter the stored values.

## Operation
Address map (byte addresses, word aligned):
- 0x00 GLOBAL, RW.
  - bit0 int_en.
  - bits[7:4] dbg_ch.
  - bit8 dbg_src: 0 selects CTRL, 1 selects STATUS.
  - Other bits read as 0. Reset value 0.
- 0x04 INT_SUM, RO. Bit i = |(STATUS_i & MASK_i). Upper bits read 0.
- 0x10+0x10·i CTRL_i, RW, 32 bits. Reset value CTRL_RESET.
- 0x14+0x10·i STATUS_i, W1C, STAT_W bits. Reset value 0.
  - Each bit is set by the matching hw_evt bit.
  - A write of 1 clears the bit. A write of 0 has no effect.
- 0x18+0x10·i MASK_i, RW, STAT_W bits. Reset value 0.

APB state machine, states IDLE and ACCESS:
- IDLE: on PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWDATA and PWRITE, clear the wait counter, and go to ACCESS.
- ACCESS: the counter increments each cycle while below WAIT_STATES.
  - PREADY = (state==ACCESS) & PENABLE & (cnt==WAIT_STATES).
  - When PREADY=1, return to IDLE.
- A write commits on the rising edge that ends the PREADY=1 cycle. Reads have no side effects.
- PSLVERR=1 together with PREADY in any of these cases. The write is dropped in each case.
  - Unmapped address, including channel index ≥ NUM_CH or offset 0xC within a channel.
  - Write to INT_SUM.
  - Misaligned address (PADDR[1:0]≠0).
- PSEL deasserted while in ACCESS aborts the transfer: return to IDLE with no commit.

Status/interrupt behaviour:
- If hw_evt and a W1C hit the same bit in the same cycle, the set wins.
- irq register next value = int_en & |INT_SUM.
- Unused STATUS/MASK bits above STAT_W read 0 and ignore writes.

Debug bus:
- debug_bus register next value = dbg_src ? zero-extended STATUS_dbg_ch : CTRL_dbg_ch.
- dbg_ch ≥ NUM_CH gives 0.

## Timing
- While RegResetn=0 at a clock edge: all registers take their reset values, state goes to IDLE, and PREADY, PSLVERR, irq and debug_bus are 0.
- Reset asserted mid-transfer discards the transfer with no commit.
- Transfer length is setup + (1+WAIT_STATES) access cycles. With WAIT_STATES=0, PREADY is high in the first PENABLE cycle.
- Register write to readback: the new value is visible on swi_ctrl one cycle after commit.
- hw_evt to STATUS: the bit is set on the next edge.
- STATUS to irq: one further cycle, so irq rises 2 edges after the hw_evt cycle.
- Register change to debug_bus: one cycle.
- Back-to-back transfers: a new setup phase is accepted in the cycle immediately after PREADY.

## Test plan
- Reset values: after reset, read every mapped address → CTRL_i=CTRL_RESET, all others 0; irq=0, debug_bus=0, PSLVERR=0.
- Wait states: with WAIT_STATES=3, write CTRL_2=0xA5A5_1234 → PREADY high exactly 4 cycles after setup; swi_ctrl[95:64]=0xA5A5_1234 on the following cycle; readback matches.
- Interrupt path: set MASK_1=0x01 and GLOBAL=0x1, then pulse hw_evt bit 8 (ch1 bit0) → STATUS_1=0x01, INT_SUM=0x2, irq=1 two edges after the pulse. Writing 0x01 to STATUS_1 clears it and irq drops one cycle later.
- Collision: hw_evt ch0 bit3 pulses in the same cycle as a W1C of 0x08 to STATUS_0 → STATUS_0 bit3 stays 1.
- Errors: access 0x0C, 0x10+0x10·NUM_CH, a write to 0x04, and address 0x11 → PSLVERR=1 with PREADY each time, and no register changes.
- Debug and DFT:
  - GLOBAL=0x0000_0130 (dbg_ch=3, dbg_src=1) with STATUS_3=0x55 → debug_bus=0x55.
  - dbg_ch=NUM_CH → debug_bus=0.
  - dft_core_scan_mode=1 → swi_ctrl=CTRL_RESET for all channels and irq=0; stored values are restored when the mode drops.
  - Reset asserted during the ACCESS wait of a write → no commit, state returns to IDLE.
